// File: rtl/timer_pkg.sv
// Shared constants for the timer datapath.
//   DIGIT_W            : width of one BCD digit.
//   MOD_SEC_UNITS/TENS : moduli of the seconds-units and seconds-tens digits.
//   DEFAULT_DIGIT_MODS : mm:ss chain, digit 0 (LSB nibble) = seconds units,
//                        digit 1 = seconds tens, digit 2 = minutes units,
//                        digit 3 = minutes tens.
package timer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] MOD_SEC_UNITS = 4'd10;
    localparam logic [DIGIT_W-1:0] MOD_SEC_TENS  = 4'd6;

    localparam logic [4*DIGIT_W-1:0] DEFAULT_DIGIT_MODS =
        {MOD_SEC_TENS, MOD_SEC_UNITS, MOD_SEC_TENS, MOD_SEC_UNITS};

endpackage

// File: rtl/counter_digit.sv
// One decrementing BCD digit with its own modulus.
// Ports:
//   clock   : clock, all state changes on posedge
//   clearn  : synchronous clear, active-low (digit <= 0)
//   loadn   : synchronous load, active-low (digit <= clamped data)
//   data    : load value; values >= MOD load as MOD-1
//   dec     : decrement this cycle; 0 decrements to MOD-1
//   digit   : current value
//   is_zero : digit == 0
module counter_digit
    import timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic               clock,
    input  logic               clearn,
    input  logic               loadn,
    input  logic [DIGIT_W-1:0] data,
    input  logic               dec,
    output logic [DIGIT_W-1:0] digit,
    output logic               is_zero
);

    localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(MOD - 1);

    function automatic logic [DIGIT_W-1:0] clamp(input logic [DIGIT_W-1:0] d);
        return (int'(d) >= MOD) ? MAX : d;
    endfunction

    always_ff @(posedge clock) begin
        if (!clearn) begin
            digit <= '0;
        end else if (!loadn) begin
            digit <= clamp(data);
        end else if (dec) begin
            digit <= is_zero ? MAX : digit - DIGIT_W'(1);
        end
    end

    assign is_zero = (digit == '0);

endmodule

// File: rtl/timer_counter_chain.sv
// Multi-digit BCD down-counter chain (e.g. mm:ss countdown).
// Ports:
//   clock  : clock, all state changes on posedge
//   clearn : synchronous clear, active-low, highest priority
//   loadn  : synchronous load of the whole chain, active-low
//   en     : count enable
//   data   : load value, digit i at [4i+3:4i]
//   digits : current count, same packing as data
//   zero   : all digits are 0 (combinational)
//   tc     : en & zero (combinational), cascade to a following chain
//   done   : registered one-cycle pulse after counting into all-zero
module timer_counter_chain
    import timer_pkg::*;
#(
    parameter int                            NUM_DIGITS   = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DIGIT_MODS   = DEFAULT_DIGIT_MODS,
    parameter bit                            HOLD_AT_ZERO = 1'b1
) (
    input  logic                          clock,
    input  logic                          clearn,
    input  logic                          loadn,
    input  logic                          en,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          zero,
    output logic                          tc,
    output logic                          done
);

    localparam int                 W   = DIGIT_W * NUM_DIGITS;
    localparam logic [W-1:0]       ONE = W'(1);

    logic [NUM_DIGITS-1:0] is_zero;
    logic [NUM_DIGITS-1:0] dec;
    logic                  count_en;
    logic                  borrow;

    assign zero     = &is_zero;
    assign tc       = en & zero;
    // In hold mode the all-zero state swallows the enable; in wrap mode the
    // enable at all-zero borrows through every digit, loading all maxima.
    assign count_en = en & ~(HOLD_AT_ZERO & zero);

    // Borrow ripple: digit i steps only when every lower digit is 0.
    always_comb begin
        borrow = 1'b1;
        dec    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dec[i] = count_en & borrow;
            borrow = borrow & is_zero[i];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_digit
        counter_digit #(
            .MOD (int'(DIGIT_MODS[DIGIT_W*g +: DIGIT_W]))
        ) u_digit (
            .clock   (clock),
            .clearn  (clearn),
            .loadn   (loadn),
            .data    (data[DIGIT_W*g +: DIGIT_W]),
            .dec     (dec[g]),
            .digit   (digits[DIGIT_W*g +: DIGIT_W]),
            .is_zero (is_zero[g])
        );
    end

    // A counting edge lands on all-zero from a non-zero value only when the
    // chain reads ...0001: digit 0 goes 1->0 and the borrow stays blocked.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            done <= 1'b0;
        end else if (!loadn) begin
            done <= 1'b0;
        end else begin
            done <= count_en & (digits == ONE);
        end
    end

endmodule
